// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 16-bit RISC core: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB, gates datapath strobes, counts retirements, traps on bus timeout.
module multicycle_sequencer #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write_gate,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             bus_error,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExecute = 3'd3,
        StMem     = 3'd4,
        StWb      = 3'd5,
        StError   = 3'd7
    } state_e;

    localparam logic [3:0] OpLw  = 4'hB;
    localparam logic [3:0] OpSw  = 4'hC;
    localparam logic [3:0] OpBeq = 4'hD;
    localparam logic [3:0] OpJmp = 4'hE;
    localparam logic [3:0] OpNop = 4'hF;

    localparam logic [1:0] PcPlus1  = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

    if (MAX_WAIT < 1 || MAX_WAIT > (2 ** WAIT_W) - 1) begin : g_bad_max_wait
        $error("MAX_WAIT must lie in 1..2^WAIT_W-1");
    end

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              timeout;
    logic              is_sw;

    assign timeout = (wait_q == MaxWait);
    assign is_sw   = (opcode == OpSw);

    always_comb begin
        state_d        = state_q;
        wait_d         = '0;
        imem_req       = 1'b0;
        ir_load        = 1'b0;
        pc_write       = 1'b0;
        pc_src         = PcPlus1;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        reg_write_gate = 1'b0;
        retire         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (imem_ready) begin
                    imem_req = 1'b1;
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timeout) begin
                    // Timeout edge is silent: the request is withdrawn as we trap.
                    state_d = StError;
                end else begin
                    imem_req = 1'b1;
                    wait_d   = wait_q + WAIT_W'(1);
                end
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMem;
                    OpBeq: begin
                        pc_write = zero;
                        pc_src   = PcBranch;
                        retire   = 1'b1;
                    end
                    OpJmp: begin
                        pc_write = 1'b1;
                        pc_src   = PcJump;
                        retire   = 1'b1;
                    end
                    OpNop:   retire  = 1'b1;
                    default: state_d = StWb;
                endcase
            end
            StMem: begin
                if (dmem_ready) begin
                    dmem_req = 1'b1;
                    dmem_we  = is_sw;
                    if (is_sw) begin
                        retire = 1'b1;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    state_d = StError;
                end else begin
                    dmem_req = 1'b1;
                    dmem_we  = is_sw;
                    wait_d   = wait_q + WAIT_W'(1);
                end
            end
            StWb: begin
                reg_write_gate = 1'b1;
                retire         = 1'b1;
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (retire) begin
            state_d = run ? StFetch : StIdle;
        end
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    assign instret   = instret_q;
    assign bus_error = (state_q == StError);
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: each instruction is expanded into its expected per-cycle output trace,
// which a single compare process checks against the DUT on every falling edge.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  opcode;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req, ir_load, pc_write, dmem_req, dmem_we, reg_write_gate, retire;
    logic [1:0]  pc_src;
    logic [15:0] instret;
    logic        bus_error;
    logic [2:0]  state;

    // Narrow-counter instance used only to reach the instret wrap quickly.
    logic        w_run;
    logic        w_imem_req, w_ir_load, w_pc_write, w_dmem_req, w_dmem_we, w_rwg, w_retire;
    logic [1:0]  w_pc_src;
    logic [3:0]  w_instret;
    logic        w_bus_error;
    logic [2:0]  w_state;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_sequencer u_dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .opcode         (opcode),
        .zero           (zero),
        .imem_ready     (imem_ready),
        .dmem_ready     (dmem_ready),
        .imem_req       (imem_req),
        .ir_load        (ir_load),
        .pc_write       (pc_write),
        .pc_src         (pc_src),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .reg_write_gate (reg_write_gate),
        .retire         (retire),
        .instret        (instret),
        .bus_error      (bus_error),
        .state          (state)
    );

    multicycle_sequencer #(
        .MAX_WAIT (15),
        .WAIT_W   (4),
        .CNT_W    (4)
    ) u_dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .run            (w_run),
        .opcode         (4'hF),
        .zero           (1'b0),
        .imem_ready     (1'b1),
        .dmem_ready     (1'b0),
        .imem_req       (w_imem_req),
        .ir_load        (w_ir_load),
        .pc_write       (w_pc_write),
        .pc_src         (w_pc_src),
        .dmem_req       (w_dmem_req),
        .dmem_we        (w_dmem_we),
        .reg_write_gate (w_rwg),
        .retire         (w_retire),
        .instret        (w_instret),
        .bus_error      (w_bus_error),
        .state          (w_state)
    );

    typedef struct {
        bit          chk;
        string       name;
        logic [28:0] v;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] exp_instret;

    // Expected layout: state, imem_req, ir_load, pc_write, pc_src, dmem_req, dmem_we,
    // reg_write_gate, retire, bus_error, instret.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t        e;
            logic [28:0] act;
            e   = expq.pop_front();
            act = {state, imem_req, ir_load, pc_write, pc_src, dmem_req, dmem_we,
                   reg_write_gate, retire, bus_error, instret};
            if (e.chk) begin
                n_assert++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %b_%b%b%b_%b_%b%b%b%b%b_%h want %b_%b%b%b_%b_%b%b%b%b%b_%h",
                             e.name, $time,
                             act[28:26], act[25], act[24], act[23], act[22:21], act[20], act[19],
                             act[18], act[17], act[16], act[15:0],
                             e.v[28:26], e.v[25], e.v[24], e.v[23], e.v[22:21], e.v[20], e.v[19],
                             e.v[18], e.v[17], e.v[16], e.v[15:0]);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_assert++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic step(input string nm, input logic [2:0] st, input logic ireq, input logic irl,
                        input logic pcw, input logic [1:0] pcs, input logic dreq,
                        input logic dwe, input logic rwg, input logic ret);
        exp_t e;
        e.chk  = 1'b1;
        e.name = nm;
        e.v    = {st, ireq, irl, pcw, pcs, dreq, dwe, rwg, ret, (st == 3'd7), exp_instret};
        expq.push_back(e);
        @(posedge clk);
        #1;
        if (ret) exp_instret = exp_instret + 16'd1;
    endtask

    task automatic skip_cycle();
        exp_t e;
        e.chk  = 1'b0;
        e.name = "skip";
        e.v    = '0;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        skip_cycle();
        rst         = 1'b0;
        exp_instret = 16'd0;
    endtask

    task automatic idle_cyc(input int n);
        run        = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int i = 0; i < n; i++) step("idle", 3'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic kick();
        run = 1'b1;
        step("idle_run", 3'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic fetch(input int fwait);
        run        = 1'b1;
        dmem_ready = 1'b1;
        imem_ready = 1'b0;
        for (int i = 0; i < fwait; i++) step("fetch_wait", 3'd1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        imem_ready = 1'b1;
        step("fetch", 3'd1, 1, 1, 1, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic decode();
        step("decode", 3'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic exec_rest(input logic [3:0] op, input int mwait, input logic z,
                             input logic run_after);
        logic sw;
        sw   = (op == 4'hC);
        zero = z;
        if (op <= 4'hA) begin
            step("exec_alu", 3'd3, 0, 0, 0, 2'b00, 0, 0, 0, 0);
            zero = ~z;
            run  = run_after;
            step("wb", 3'd5, 0, 0, 0, 2'b00, 0, 0, 1, 1);
        end else if (op == 4'hB || op == 4'hC) begin
            step("exec_mem", 3'd3, 0, 0, 0, 2'b00, 0, 0, 0, 0);
            zero       = ~z;
            run        = run_after;
            dmem_ready = 1'b0;
            for (int i = 0; i < mwait; i++) step("mem_wait", 3'd4, 0, 0, 0, 2'b00, 1, sw, 0, 0);
            dmem_ready = 1'b1;
            step("mem_done", 3'd4, 0, 0, 0, 2'b00, 1, sw, 0, sw);
            if (!sw) step("wb", 3'd5, 0, 0, 0, 2'b00, 0, 0, 1, 1);
        end else begin
            run = run_after;
            if (op == 4'hD) step("exec_beq", 3'd3, 0, 0, z, 2'b01, 0, 0, 0, 1);
            else if (op == 4'hE) step("exec_jmp", 3'd3, 0, 0, 1, 2'b10, 0, 0, 0, 1);
            else step("exec_nop", 3'd3, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        end
        zero = ~z;
    endtask

    task automatic run_instr(input logic [3:0] op, input int fwait, input int mwait,
                             input logic z, input logic run_after);
        opcode = op;
        zero   = ~z;
        fetch(fwait);
        decode();
        exec_rest(op, mwait, z, run_after);
    endtask

    task automatic error_cycles(input int n);
        run        = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int i = 0; i < n; i++) step("error", 3'd7, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        run         = 1'b0;
        w_run       = 1'b0;
        opcode      = 4'h0;
        zero        = 1'b0;
        imem_ready  = 1'b1;
        dmem_ready  = 1'b1;
        exp_instret = 16'd0;
        @(posedge clk);
        #1;
        do_reset();
        lit("reset_state", 32'(state), 32'd0);
        lit("reset_instret", 32'(instret), 32'd0);
        lit("reset_bus_error", 32'(bus_error), 32'd0);
        idle_cyc(2);

        // Wrap: 16 NOPs on a 4-bit counter, 3 cycles each after the kick cycle.
        lit("wrap_reset", 32'(w_instret), 32'd0);
        w_run = 1'b1;
        idle_cyc(1);
        for (int i = 0; i < 15; i++) idle_cyc(3);
        lit("wrap_max", 32'(w_instret), 32'hF);
        idle_cyc(3);
        lit("wrap_zero", 32'(w_instret), 32'h0);
        w_run = 1'b0;
        idle_cyc(4);

        kick();
        run_instr(4'h0, 0, 0, 1'b0, 1'b1);
        lit("alu_instret", 32'(instret), 32'd1);
        lit("alu_back_to_fetch", 32'(state), 32'd1);

        run_instr(4'hB, 1, 3, 1'b0, 1'b1);
        run_instr(4'hC, 0, 0, 1'b0, 1'b1);
        run_instr(4'hC, 2, 2, 1'b1, 1'b1);
        lit("mem_instret", 32'(instret), 32'd4);

        run_instr(4'hD, 0, 0, 1'b1, 1'b1);
        run_instr(4'hD, 0, 0, 1'b0, 1'b1);
        run_instr(4'hE, 0, 0, 1'b0, 1'b1);
        run_instr(4'hF, 0, 0, 1'b0, 1'b1);
        run_instr(4'hA, 0, 0, 1'b0, 1'b1);
        run_instr(4'h5, 15, 0, 1'b0, 1'b1);
        run_instr(4'hB, 0, 15, 1'b0, 1'b1);

        // run drops during MEM: the load still completes, then the core parks.
        run_instr(4'hB, 0, 2, 1'b0, 1'b0);
        lit("run_drop_idle", 32'(state), 32'd0);
        lit("run_drop_instret", 32'(instret), 32'd12);
        idle_cyc(2);

        // Reset while in EXECUTE.
        kick();
        opcode = 4'h3;
        fetch(0);
        decode();
        lit("in_execute", 32'(state), 32'd3);
        do_reset();
        lit("rst_exec_state", 32'(state), 32'd0);
        lit("rst_exec_instret", 32'(instret), 32'd0);
        idle_cyc(2);

        // Instruction fetch timeout.
        kick();
        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step("fetch_wait", 3'd1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        step("fetch_timeout", 3'd1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        lit("fetch_err_flag", 32'(bus_error), 32'd1);
        error_cycles(4);
        do_reset();
        lit("err_cleared", 32'(bus_error), 32'd0);
        lit("err_cleared_state", 32'(state), 32'd0);
        idle_cyc(1);

        // Data memory timeout on a store.
        kick();
        run_instr(4'h1, 0, 0, 1'b0, 1'b1);
        opcode = 4'hC;
        fetch(0);
        decode();
        step("exec_mem", 3'd3, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        dmem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step("mem_wait", 3'd4, 0, 0, 0, 2'b00, 1, 1, 0, 0);
        step("mem_timeout", 3'd4, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        error_cycles(3);
        lit("mem_err_instret", 32'(instret), 32'd1);
        do_reset();
        idle_cyc(2);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit RISC core; sits between the instruction decoder and the datapath.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB. Gates PC, IR, register-file and memory strobes from opcode class.
- Handshakes with instruction and data memory. Counts retired instructions. Traps on memory timeout.

Parameters:
- MAX_WAIT, 15, maximum consecutive wait cycles on imem/dmem before bus error (1..2^WAIT_W-1)
- WAIT_W, 4, width of the wait counter
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  level enable; sampled in IDLE and at every retire
- opcode  input  4  IR[15:12] of the current instruction (valid from DECODE onward)
- zero  input  1  ALU zero flag for BEQ, valid in EXECUTE
- imem_ready  input  1  instruction memory has data this cycle
- dmem_ready  input  1  data memory completed access this cycle
- imem_req  output  1  instruction fetch request
- ir_load  output  1  latch instruction register
- pc_write  output  1  PC update strobe
- pc_src  output  2  00=PC+1, 01=branch target, 10=jump target
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (SW)
- reg_write_gate  output  1  qualifies decoder reg_write_enable
- retire  output  1  one-cycle pulse per completed instruction
- instret  output  CNT_W  retired-instruction count
- bus_error  output  1  sticky memory-timeout flag
- state  output  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, ERROR=7

Behaviour:
- Reset: state=IDLE, instret=0, bus_error=0, wait counter=0. All strobes 0; pc_src=00. Reset mid-operation drops every request on the same edge.
- All strobes are Moore/Mealy combinational from state plus inputs, as listed below. Default 0.
- IDLE: run=1 -> FETCH; else stay.
- FETCH: imem_req=1.
  - imem_ready=1 -> ir_load=1, pc_write=1, pc_src=00 that cycle; next DECODE.
  - Otherwise the wait counter increments.
- DECODE: single cycle -> EXECUTE.
- EXECUTE, by opcode:
  - 0x0..0xA (ALU/ALU-imm) -> WB.
  - 0xB (LW), 0xC (SW) -> MEM.
  - 0xD (BEQ): pc_write=zero, pc_src=01; retire.
  - 0xE (JMP): pc_write=1, pc_src=10; retire.
  - 0xF (NOP): retire.
- MEM: dmem_req=1; dmem_we=1 iff opcode=0xC.
  - dmem_ready=1 -> LW goes to WB; SW retires.
  - Otherwise the wait counter increments.
- WB: reg_write_gate=1 for exactly one cycle; retire.
- Retire:
  - retire=1 in the cycle of the retiring transition; instret += 1 on that edge, wrapping at 2^CNT_W-1 -> 0.
  - Next state is FETCH if run=1, else IDLE. run dropping mid-instruction does not abort the instruction.
- Wait counter:
  - Clears on every state change and whenever ready=1.
  - If ready=0 while counter==MAX_WAIT, next state=ERROR. No strobe is asserted on the timeout edge.
- ERROR: bus_error=1 and all strobes 0 until rst. run is ignored.
- ready asserted on the same cycle as the request is zero-wait: the transition happens that edge.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.

Test Plan:
- Reset, then run=1, imem_ready=1 always, opcode=0x0 -> states 1,2,3,5,1. ir_load and pc_write pulse in FETCH. reg_write_gate high 1 cycle. retire once, instret=1, 4 cycles/instr.
- LW (0xB) with dmem_ready delayed 3 cycles -> MEM held 4 cycles, dmem_req=1, dmem_we=0. Then WB, instret increments. SW (0xC) -> dmem_we=1 in MEM, retires from MEM without WB.
- BEQ with zero=1 -> pc_write=1, pc_src=01 in EXECUTE. zero=0 -> pc_write=0. JMP -> pc_src=10, pc_write=1. Both retire in EXECUTE.
- imem_ready held 0, MAX_WAIT=15 -> ERROR after 16 FETCH cycles, bus_error=1 sticky. imem_ready later 1 has no effect. rst clears to IDLE, bus_error=0.
- Preload instret to 0xFFFF via 65535 NOPs (or force), then one retire -> instret=0x0000.
- run dropped during MEM -> instruction completes, retire=1, then IDLE. rst asserted in EXECUTE -> next cycle IDLE, all strobes 0, instret=0.
